huffman_pack_ctrl: RTL and testbench
====================================

# huffman_pack_ctrl

Controller that sequences a Huffman encode pass. It holds a symbol-indexed code table loaded over a write port and accepts 8-bit symbols on a valid/ready stream. Each symbol's variable-length code is looked up and packed MSB-first into fixed-width output words, also on a valid/ready stream. It sits between the symbol source and the compressed-word sink, replacing the free-running table lookup with a handshaked, back-pressured, flushable pipeline.

## Interface
- SYM_W, 8, symbol width; table depth is 2^SYM_W
- MAX_LEN, 16, maximum code length in bits
- LEN_W, 5, code-length field width ($clog2(MAX_LEN+1))
- OUT_W, 32, output word width
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- tbl_we  in  1  table write strobe
- tbl_addr  in  SYM_W  table entry (symbol) to write
- tbl_code  in  MAX_LEN  code, right-aligned; bit [len-1] is transmitted first
- tbl_len  in  LEN_W  code length
- start  in  1  begin an encode pass (pulse)
- sym_valid  in  1  symbol available
- sym_ready  out  1  symbol accepted when valid&ready
- sym_data  in  SYM_W  symbol
- sym_last  in  1  final symbol of the pass
- out_valid  out  1  output word available
- out_ready  in  1  sink accepts word
- out_data  out  OUT_W  packed bits, MSB-first, zero-padded
- out_bits  out  $clog2(OUT_W)+1  valid bits in out_data
- out_last  out  1  final word of the pass
- busy  out  1  state != IDLE
- err  out  1  sticky: zero-length/unwritten code used, or illegal table write

## Operation
- Table: 2^SYM_W entries of {valid, code, len}. Reset clears every valid bit. Code and length contents are not reset.
- A write sets valid=1 and is accepted only in IDLE.
- A write with tbl_len > MAX_LEN is dropped and sets err.
- A write while busy is dropped silently.
- Accumulator acc: OUT_W+MAX_LEN bits, filled from the MSB. Fill count cnt ranges 0..OUT_W+MAX_LEN-1.
- States: IDLE, RUN, FLUSH.
- IDLE → RUN on start. That cycle clears err and cnt. start outside IDLE is ignored.
- In RUN, sym_ready = (cnt < OUT_W).
- On symbol accept, the code's len bits are appended at bit position cnt from the MSB, and cnt += len.
- An entry with valid=0 or len=0 appends nothing and sets err. The symbol is still consumed.
- An accepted symbol with sym_last=1 moves the block RUN → FLUSH.
- In RUN, out_valid = (cnt >= OUT_W), with out_data = acc top OUT_W bits, out_bits = OUT_W, out_last = 0.
- On an output handshake: acc <<= OUT_W, cnt -= OUT_W.
- sym_ready and out_valid are mutually exclusive in RUN, so no cycle both appends and emits.
- In FLUSH, out_valid = 1, out_bits = min(cnt, OUT_W), out_last = (cnt <= OUT_W), out_data = acc top OUT_W bits with unused LSBs zero.
- A FLUSH handshake with out_last=1 → IDLE, cnt = 0.
- Empty pass: if every symbol was zero-length, cnt = 0 and FLUSH emits one word with out_bits = 0, out_last = 1.
- Reset mid-pass: immediate return to IDLE. All outputs drop, accumulator is discarded, all table entries become invalid.

## Timing
- Reset values: sym_ready = 0, out_valid = 0, out_data = 0, out_bits = 0, out_last = 0, busy = 0, err = 0, cnt = 0, state = IDLE.
- A table write at edge k is visible to lookups from cycle k+1.
- start sampled at edge k puts the block in RUN with sym_ready = 1 during cycle k+1.
- A symbol accepted at edge k has its bits in acc at cycle k+1.
- out_valid can assert in cycle k+1 (one-cycle latency). No combinational path exists from sym_valid to out_valid.
- sym_ready depends only on registered state and cnt. It never depends on sym_valid.
- Output stability: once out_valid = 1, out_data, out_bits and out_last stay stable until the handshake.
- Sustained throughput: one word per cycle while draining; one symbol per cycle while cnt < OUT_W.
- err rises the cycle after the offending event and holds until the next accepted start or reset.

## Structure
- Package huffman_pkg holds:
  - default constants SYM_W, MAX_LEN, LEN_W, OUT_W
  - state enum {IDLE, RUN, FLUSH}
  - table entry struct {valid, code[MAX_LEN], len[LEN_W]}
- Sub-module huffman_code_table: entry storage with reset of valid bits, write port with gating inputs, combinational read by sym_data.
- The top level holds the FSM, accumulator and shifter, and the handshake logic.

## Test plan
- Reset with rst_n = 0 → every output 0. Release, assert start → busy = 1 and sym_ready = 1 the next cycle.
- Table sym 0x01 = code 0b101 len 3, sym 0x02 = 0b1 len 1. Send 0x01, then 0x02 with last → single word 0xB0000000, out_bits = 4, out_last = 1, then busy = 0.
- Sym 0x07 = 0b111 len 3. Send 11 × 0x07 (last on the 11th) → 0xFFFFFFFF / bits 32 / last 0, then 0x80000000 / bits 1 / last 1.
- Backpressure: cnt ≥ 32 with out_ready low for 20 cycles → out_data held constant and sym_ready = 0 throughout. Release → drains one word per cycle.
- Errors: use an unwritten sym 0x55 → err = 1 and no bits added. tbl_we during RUN → entry unchanged. tbl_len = 17 in IDLE → err = 1. An all-zero-length pass → one word with out_bits = 0, out_last = 1.
- Drop rst_n during FLUSH with out_valid = 1 → IDLE immediately, outputs 0, previously written symbols now flag err.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and table entry layout for the Huffman packer.
package huffman_pkg;

  localparam int SYM_W   = 8;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int OUT_W   = 32;
  localparam int ACC_W   = OUT_W + MAX_LEN;
  localparam int CNT_W   = $clog2(ACC_W);
  localparam int BITS_W  = $clog2(OUT_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } stateT;

  typedef struct packed {
    logic               valid;
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } tableEntryT;

  // Positions a right-aligned code so its first bit lands at offset fillCnt from the accumulator MSB.
  // Code bits above len are masked off so stale table contents cannot leak into the stream.
  function automatic logic [ACC_W-1:0] placeCode(input logic [MAX_LEN-1:0] code,
                                                 input logic [LEN_W-1:0]   len,
                                                 input logic [CNT_W-1:0]   fillCnt);
    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] wide;
    logic [CNT_W:0]   shAmt;
    mask  = (ACC_W'(1) << len) - ACC_W'(1);
    wide  = ACC_W'(code) & mask;
    shAmt = (CNT_W+1)'(ACC_W) - {1'b0, fillCnt} - (CNT_W+1)'(len);
    return wide << shAmt;
  endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Symbol-indexed code table: valid bits are reset, code/length storage is not.
module huffman_code_table
  import huffman_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrEn,
  input  logic [SYM_W-1:0]   wrAddr,
  input  logic [MAX_LEN-1:0] wrCode,
  input  logic [LEN_W-1:0]   wrLen,
  input  logic [SYM_W-1:0]   rdAddr,
  output tableEntryT         rdEntry
);

  localparam int DEPTH = 2 ** SYM_W;

  logic [DEPTH-1:0]   validBits;
  logic [MAX_LEN-1:0] codeMem [DEPTH];
  logic [LEN_W-1:0]   lenMem  [DEPTH];

  // Valid flags: cleared on reset so every symbol must be rewritten before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validBits <= '0;
    end else if (wrEn) begin
      validBits[wrAddr] <= 1'b1;
    end
  end

  // Code and length payload: plain storage, contents only meaningful once valid.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      codeMem[wrAddr] <= wrCode;
      lenMem[wrAddr]  <= wrLen;
    end
  end

  assign rdEntry = '{valid: validBits[rdAddr], code: codeMem[rdAddr], len: lenMem[rdAddr]};

endmodule

// File: rtl/huffman_pack_ctrl.sv
// Huffman encode controller: looks up each symbol's code and packs it MSB-first into output words.
module huffman_pack_ctrl
  import huffman_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic               start,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [SYM_W-1:0]   sym_data,
  input  logic               sym_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [BITS_W-1:0]  out_bits,
  output logic               out_last,
  output logic               busy,
  output logic               err
);

  stateT            state;
  stateT            stateNext;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             errReg;
  tableEntryT       entry;
  logic             tblWrEn;
  logic             tblBadWrite;
  logic             symAccept;
  logic             outAccept;
  logic             startAccept;

  assign tblWrEn     = tbl_we && (state == IDLE) && (tbl_len <= LEN_W'(MAX_LEN));
  assign tblBadWrite = tbl_we && (state == IDLE) && (tbl_len > LEN_W'(MAX_LEN));
  assign startAccept = (state == IDLE) && start;
  assign symAccept   = sym_valid && sym_ready;
  assign outAccept   = out_valid && out_ready;

  huffman_code_table codeTable (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrEn    (tblWrEn),
    .wrAddr  (tbl_addr),
    .wrCode  (tbl_code),
    .wrLen   (tbl_len),
    .rdAddr  (sym_data),
    .rdEntry (entry)
  );

  // State register for the IDLE/RUN/FLUSH sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and handshake outputs; all derived from registered state so sym_ready never sees sym_valid.
  always_comb begin
    stateNext = state;
    sym_ready = 1'b0;
    out_valid = 1'b0;
    out_bits  = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = RUN;
      end
      RUN: begin
        sym_ready = (cnt < CNT_W'(OUT_W));
        out_valid = !(cnt < CNT_W'(OUT_W));
        out_bits  = BITS_W'(OUT_W);
        if (sym_valid && sym_ready && sym_last) stateNext = FLUSH;
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_bits  = (cnt >= CNT_W'(OUT_W)) ? BITS_W'(OUT_W) : BITS_W'(cnt);
        out_last  = (cnt <= CNT_W'(OUT_W));
        if (out_ready && out_last) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Accumulator, fill count and sticky error: append on symbol accept, shift out on word accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      errReg <= 1'b0;
    end else begin
      if (startAccept) begin
        acc    <= '0;
        cnt    <= '0;
        errReg <= 1'b0;
      end
      if (symAccept) begin
        if (entry.valid && (entry.len != '0)) begin
          acc <= acc | placeCode(entry.code, entry.len, cnt);
          cnt <= cnt + CNT_W'(entry.len);
        end else begin
          errReg <= 1'b1;
        end
      end
      if (outAccept) begin
        if (out_last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc << OUT_W;
          cnt <= cnt - CNT_W'(OUT_W);
        end
      end
      if (tblBadWrite) errReg <= 1'b1;
    end
  end

  // Unused LSBs are already zero because the accumulator only ever shifts in zeros.
  assign out_data = out_valid ? acc[ACC_W-1 -: OUT_W] : '0;
  assign busy     = (state != IDLE);
  assign err      = errReg;

endmodule

// File: tb/tb_huffman_pack_ctrl.sv
// Directed self-checking bench for huffman_pack_ctrl.
module tb_huffman_pack_ctrl;
  import huffman_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               tbl_we;
  logic [SYM_W-1:0]   tbl_addr;
  logic [MAX_LEN-1:0] tbl_code;
  logic [LEN_W-1:0]   tbl_len;
  logic               start;
  logic               sym_valid;
  logic               sym_ready;
  logic [SYM_W-1:0]   sym_data;
  logic               sym_last;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic [BITS_W-1:0]  out_bits;
  logic               out_last;
  logic               busy;
  logic               err;

  int checks = 0;
  int errors = 0;

  huffman_pack_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_code  (tbl_code),
    .tbl_len   (tbl_len),
    .start     (start),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .sym_last  (sym_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the stimulus ever stalls outside a bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tblWrite(input logic [7:0] sym, input logic [15:0] code, input logic [4:0] len);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = sym; tbl_code = code; tbl_len = len;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] sym, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    sym_valid = 1'b1; sym_data = sym; sym_last = last;
    while (!sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sym_ready) checkOutput("symReadyTimeout", 64'(sym_ready), 64'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0;
  endtask

  task automatic receiveWord(input string tag, input logic [31:0] expData, input logic [5:0] expBits, input logic expLast);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_data"}, 64'(out_data), 64'(expData));
    checkOutput({tag, "_bits"}, 64'(out_bits), 64'(expBits));
    checkOutput({tag, "_last"}, 64'(out_last), 64'(expLast));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
    start = 1'b0; sym_valid = 1'b0; sym_data = '0; sym_last = 1'b0; out_ready = 1'b0;

    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    checkOutput("rst_symReady", 64'(sym_ready), 64'd0);
    checkOutput("rst_outValid", 64'(out_valid), 64'd0);
    checkOutput("rst_outData", 64'(out_data), 64'd0);
    checkOutput("rst_outBits", 64'(out_bits), 64'd0);
    checkOutput("rst_outLast", 64'(out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    $display("[TB] basic two-symbol pass");
    tblWrite(8'h01, 16'b101, 5'd3);
    tblWrite(8'h02, 16'b1, 5'd1);
    tblWrite(8'h07, 16'b111, 5'd3);
    pulseStart();
    @(negedge clk);
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_symReady", 64'(sym_ready), 64'd1);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b1);
    receiveWord("basic", 32'hB000_0000, 6'd4, 1'b1);
    @(negedge clk);
    checkOutput("basic_idle", 64'(busy), 64'd0);

    $display("[TB] 33-bit pass drained back to back");
    pulseStart();
    for (int i = 0; i < 11; i++) applyStimulus(8'h07, (i == 10));
    @(negedge clk);
    checkOutput("two_w0_valid", 64'(out_valid), 64'd1);
    checkOutput("two_w0_data", 64'(out_data), 64'hFFFF_FFFF);
    checkOutput("two_w0_bits", 64'(out_bits), 64'd32);
    checkOutput("two_w0_last", 64'(out_last), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("two_w1_valid", 64'(out_valid), 64'd1);
    checkOutput("two_w1_data", 64'(out_data), 64'h8000_0000);
    checkOutput("two_w1_bits", 64'(out_bits), 64'd1);
    checkOutput("two_w1_last", 64'(out_last), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("two_idle", 64'(busy), 64'd0);

    $display("[TB] backpressure in RUN");
    pulseStart();
    for (int i = 0; i < 11; i++) applyStimulus(8'h07, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_outValid", 64'(out_valid), 64'd1);
      checkOutput("bp_outData", 64'(out_data), 64'hFFFF_FFFF);
      checkOutput("bp_symReady", 64'(sym_ready), 64'd0);
    end
    receiveWord("bp_w0", 32'hFFFF_FFFF, 6'd32, 1'b0);
    @(negedge clk);
    checkOutput("bp_symReadyBack", 64'(sym_ready), 64'd1);
    for (int i = 0; i < 5; i++) applyStimulus(8'h07, (i == 4));
    receiveWord("bp_w1", 32'hFFFF_0000, 6'd16, 1'b1);

    $display("[TB] unwritten symbol");
    pulseStart();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h55, 1'b0);
    @(negedge clk);
    checkOutput("unwr_err", 64'(err), 64'd1);
    applyStimulus(8'h02, 1'b1);
    receiveWord("unwr", 32'hB000_0000, 6'd4, 1'b1);

    $display("[TB] table write during RUN is ignored");
    pulseStart();
    @(negedge clk);
    checkOutput("run_errCleared", 64'(err), 64'd0);
    tblWrite(8'h01, 16'b1111, 5'd4);
    applyStimulus(8'h01, 1'b1);
    receiveWord("runwr", 32'hA000_0000, 6'd3, 1'b1);
    checkOutput("runwr_err", 64'(err), 64'd0);

    $display("[TB] illegal length write");
    tblWrite(8'h03, 16'h0001, 5'd17);
    @(negedge clk);
    checkOutput("badlen_err", 64'(err), 64'd1);

    $display("[TB] zero-length pass");
    tblWrite(8'h04, 16'h0000, 5'd0);
    pulseStart();
    @(negedge clk);
    checkOutput("zero_errCleared", 64'(err), 64'd0);
    applyStimulus(8'h04, 1'b1);
    receiveWord("zero", 32'h0000_0000, 6'd0, 1'b1);
    checkOutput("zero_err", 64'(err), 64'd1);

    $display("[TB] reset during FLUSH");
    pulseStart();
    applyStimulus(8'h01, 1'b1);
    @(negedge clk);
    checkOutput("rflush_outValid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rflush_outValid0", 64'(out_valid), 64'd0);
    checkOutput("rflush_outData0", 64'(out_data), 64'd0);
    checkOutput("rflush_outBits0", 64'(out_bits), 64'd0);
    checkOutput("rflush_outLast0", 64'(out_last), 64'd0);
    checkOutput("rflush_busy0", 64'(busy), 64'd0);
    checkOutput("rflush_symReady0", 64'(sym_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulseStart();
    applyStimulus(8'h01, 1'b1);
    @(negedge clk);
    checkOutput("rflush_staleErr", 64'(err), 64'd1);
    receiveWord("rflush", 32'h0000_0000, 6'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
